// File: rtl/scanner_ctrl_param.sv
// scanner_ctrl_param: parametrised scanner handshake FSM with buffer-occupancy model; SCANNER_IDLE_TIMEOUT_EN enables IDLE auto-flush
module scanner_ctrl_param #(
  parameter int SCAN_CYCLES = 10,
  parameter int FLUSH_CYCLES = 5,
  parameter int STBY_LEAD = 2,
  parameter int SCAN_LEAD = 1,
  parameter int FLUSH_LEAD = 4,
  parameter int DEPTH = 16,
  parameter int CNT_W = 8,
  parameter int IDLE_TIMEOUT = 32,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       userInput,
  input  logic [1:0]       receiveComm,
  output logic [1:0]       transmitComm,
  output logic [2:0]       ps,
  output logic [CNT_W-1:0] count,
  output logic [LVL_W-1:0] bufLevel,
  output logic             dataValid,
  output logic             overflow
);
  localparam logic [2:0] LOWPOWER = 3'b000;
  localparam logic [2:0] STANDBY = 3'b001;
  localparam logic [2:0] COLLECTING = 3'b010;
  localparam logic [2:0] IDLE = 3'b011;
  localparam logic [2:0] TRANSFERRING = 3'b100;
  localparam logic [2:0] FLUSHING = 3'b101;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STBY_AT = CNT_W'(SCAN_CYCLES - 1 - STBY_LEAD);
  localparam logic [CNT_W-1:0] SCAN_AT = CNT_W'(SCAN_CYCLES - 1 - SCAN_LEAD);
  localparam logic [CNT_W-1:0] FLUSH_AT = CNT_W'(SCAN_CYCLES - 1 - FLUSH_LEAD);
  localparam bit STBY_ON = STBY_LEAD < SCAN_CYCLES;
  localparam bit SCAN_ON = SCAN_LEAD < SCAN_CYCLES;
  localparam bit FLUSH_ON = FLUSH_LEAD < SCAN_CYCLES;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);
`ifdef SCANNER_IDLE_TIMEOUT_EN
  localparam bit IDLE_RUN = 1'b1;
`else
  localparam bit IDLE_RUN = 1'b0;
`endif

  logic [2:0] ns;
  logic       idle_to;
  logic       cnt_run;

  assign idle_to = IDLE_RUN && count == IDLE_LAST;
  assign cnt_run = ps == COLLECTING || ps == FLUSHING || (IDLE_RUN && ps == IDLE);
  assign dataValid = ps == TRANSFERRING;
  // flush lead outranks scan lead, which outranks standby lead, when they land on the same count
  assign transmitComm = ps != COLLECTING ? 2'b00 :
                        (FLUSH_ON && count == FLUSH_AT) ? 2'b11 :
                        (SCAN_ON && count == SCAN_AT) ? 2'b10 :
                        (STBY_ON && count == STBY_AT) ? 2'b01 : 2'b00;

  // next-state selection; peer commands outside their consuming state fall through unused
  always_comb begin
    ns = LOWPOWER;
    case (ps)
      LOWPOWER: ns = (userInput[0] || receiveComm == 2'b01) ? STANDBY : LOWPOWER;
      STANDBY: ns = (userInput[2] || receiveComm == 2'b10) ? COLLECTING : STANDBY;
      COLLECTING: ns = count == SCAN_LAST ? IDLE : COLLECTING;
      IDLE: ns = userInput[1] ? TRANSFERRING : (receiveComm == 2'b11 || idle_to) ? FLUSHING : IDLE;
      TRANSFERRING: ns = bufLevel <= LVL_W'(1) ? LOWPOWER : TRANSFERRING;
      FLUSHING: ns = count == FLUSH_LAST ? LOWPOWER : FLUSHING;
      default: ns = LOWPOWER;
    endcase
  end

  // state register and per-state timer that restarts on every transition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps <= LOWPOWER;
      count <= '0;
    end else begin
      ps <= ns;
      count <= (ns != ps || !cnt_run) ? '0 : count + CNT_W'(1);
    end
  end

  // buffer occupancy: fill while collecting, drain while transferring, dump at end of flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bufLevel <= '0;
      overflow <= 1'b0;
    end else begin
      bufLevel <= ps == COLLECTING ? (bufLevel == FULL ? FULL : bufLevel + LVL_W'(1)) :
                  ps == TRANSFERRING ? (bufLevel == '0 ? '0 : bufLevel - LVL_W'(1)) :
                  (ps == FLUSHING && ns == LOWPOWER) ? '0 : bufLevel;
      overflow <= (ns == LOWPOWER && ps != LOWPOWER) ? 1'b0 :
                  overflow | (ps == COLLECTING && bufLevel == FULL);
    end
  end
endmodule

// File: tb/tb_scanner_ctrl_param.sv
// tb_scanner_ctrl_param: randomized session bench for scanner_ctrl_param across three parameter sets
module tb_scanner_ctrl_param;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

`ifdef SCANNER_IDLE_TIMEOUT_EN
  localparam bit IDLE_RUN = 1'b1;
`else
  localparam bit IDLE_RUN = 1'b0;
`endif

  int p_sc [3] = '{10, 20, 6};
  int p_fc [3] = '{5, 3, 2};
  int p_dep [3] = '{16, 16, 4};
  int p_sl [3] = '{2, 20, 1};
  int p_scl [3] = '{1, 3, 1};
  int p_fl [3] = '{4, 3, 0};

  int sel;
  int n_checks = 0;
  int n_fail = 0;
  logic [2:0] ui, ui0, ui1, ui2;
  logic [1:0] rc, rc0, rc1, rc2;
  logic [1:0] tx0, tx1, tx2, tx;
  logic [2:0] ps0, ps1, ps2, st;
  logic [7:0] cnt0, cnt1, cnt2, cnt, lvl;
  logic [4:0] bl0, bl1;
  logic [2:0] bl2;
  logic dv0, dv1, dv2, dv, ov0, ov1, ov2, ov;
  logic [22:0] obs;

  assign ui0 = sel == 0 ? ui : 3'b000;
  assign ui1 = sel == 1 ? ui : 3'b000;
  assign ui2 = sel == 2 ? ui : 3'b000;
  assign rc0 = sel == 0 ? rc : 2'b00;
  assign rc1 = sel == 1 ? rc : 2'b00;
  assign rc2 = sel == 2 ? rc : 2'b00;
  assign obs = {st, cnt, lvl, dv, ov, tx};

  always_comb begin
    tx = tx0; st = ps0; cnt = cnt0; lvl = 8'(bl0); dv = dv0; ov = ov0;
    if (sel == 1) begin
      tx = tx1; st = ps1; cnt = cnt1; lvl = 8'(bl1); dv = dv1; ov = ov1;
    end
    if (sel == 2) begin
      tx = tx2; st = ps2; cnt = cnt2; lvl = 8'(bl2); dv = dv2; ov = ov2;
    end
  end

  scanner_ctrl_param dut0 (
    .clk(clk), .reset(reset), .userInput(ui0), .receiveComm(rc0), .transmitComm(tx0),
    .ps(ps0), .count(cnt0), .bufLevel(bl0), .dataValid(dv0), .overflow(ov0));
  scanner_ctrl_param #(.SCAN_CYCLES(20), .FLUSH_CYCLES(3), .STBY_LEAD(20), .SCAN_LEAD(3),
    .FLUSH_LEAD(3), .DEPTH(16)) dut1 (
    .clk(clk), .reset(reset), .userInput(ui1), .receiveComm(rc1), .transmitComm(tx1),
    .ps(ps1), .count(cnt1), .bufLevel(bl1), .dataValid(dv1), .overflow(ov1));
  scanner_ctrl_param #(.SCAN_CYCLES(6), .FLUSH_CYCLES(2), .STBY_LEAD(1), .SCAN_LEAD(1),
    .FLUSH_LEAD(0), .DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .userInput(ui2), .receiveComm(rc2), .transmitComm(tx2),
    .ps(ps2), .count(cnt2), .bufLevel(bl2), .dataValid(dv2), .overflow(ov2));

  function automatic logic [1:0] exp_tx(input int k, input int i);
    if (p_fl[k] < p_sc[k] && i == p_sc[k] - 1 - p_fl[k]) return 2'b11;
    if (p_scl[k] < p_sc[k] && i == p_sc[k] - 1 - p_scl[k]) return 2'b10;
    if (p_sl[k] < p_sc[k] && i == p_sc[k] - 1 - p_sl[k]) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one full random cycle through LOWPOWER/STANDBY/COLLECTING/IDLE and then transfer or flush
  task automatic run_session(input int k, input bit flush, input bit both);
    int sc, dep, l, w;
    logic ov_e;
    sc = p_sc[k];
    dep = p_dep[k];
    l = sc < dep ? sc : dep;
    ov_e = sc > dep;
    sel = k;
    w = $urandom_range(0, 3);
    for (int j = 0; j < w; j++) begin
      ui = 3'($urandom) & 3'b110;
      rc = $urandom_range(0, 2) == 0 ? 2'b00 : 2'($urandom_range(2, 3));
      step();
      n_checks++;
      if (obs !== 23'd0) begin
        n_fail++;
        $display("FAIL lowpower_hold k=%0d got %h exp %h", k, obs, 23'd0);
      end
    end
    if ($urandom_range(0, 1) == 1) begin
      ui = 3'b001;
      rc = 2'b00;
    end else begin
      ui = 3'($urandom) & 3'b110;
      rc = 2'b01;
    end
    step();
    n_checks++;
    if (obs !== {3'd1, 8'd0, 8'd0, 1'b0, 1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL wake k=%0d got %h exp %h", k, obs, {3'd1, 8'd0, 8'd0, 1'b0, 1'b0, 2'b00});
    end
    w = $urandom_range(0, 3);
    for (int j = 0; j < w; j++) begin
      ui = 3'($urandom) & 3'b011;
      rc = $urandom_range(0, 2) == 2 ? 2'b11 : 2'($urandom_range(0, 1));
      step();
      n_checks++;
      if (st !== 3'd1) begin
        n_fail++;
        $display("FAIL standby_hold k=%0d got %0d exp 1", k, st);
      end
    end
    if ($urandom_range(0, 1) == 1) begin
      ui = 3'b100;
      rc = 2'b00;
    end else begin
      ui = 3'b000;
      rc = 2'b10;
    end
    step();
    for (int i = 0; i < sc; i++) begin
      n_checks++;
      if (obs !== {3'd2, 8'(i), 8'(i < dep ? i : dep), 1'b0, logic'(i > dep), exp_tx(k, i)}) begin
        n_fail++;
        $display("FAIL collect k=%0d i=%0d got %h exp %h", k, i, obs,
                 {3'd2, 8'(i), 8'(i < dep ? i : dep), 1'b0, logic'(i > dep), exp_tx(k, i)});
      end
      ui = 3'($urandom);
      rc = 2'($urandom);
      step();
    end
    w = $urandom_range(0, 6);
    for (int j = 0; j <= w; j++) begin
      n_checks++;
      if (obs !== {3'd3, 8'(IDLE_RUN ? j : 0), 8'(l), 1'b0, ov_e, 2'b00}) begin
        n_fail++;
        $display("FAIL idle k=%0d j=%0d got %h exp %h", k, j, obs,
                 {3'd3, 8'(IDLE_RUN ? j : 0), 8'(l), 1'b0, ov_e, 2'b00});
      end
      if (j < w) begin
        ui = 3'($urandom) & 3'b101;
        rc = 2'($urandom_range(0, 2));
        step();
      end
    end
    if (!flush) begin
      ui = 3'($urandom) | 3'b010;
      rc = both ? 2'b11 : 2'($urandom);
      step();
      for (int t = 0; t < (l > 1 ? l : 1); t++) begin
        n_checks++;
        if (obs !== {3'd4, 8'd0, 8'(l - t), 1'b1, ov_e, 2'b00}) begin
          n_fail++;
          $display("FAIL transfer k=%0d t=%0d got %h exp %h", k, t, obs,
                   {3'd4, 8'd0, 8'(l - t), 1'b1, ov_e, 2'b00});
        end
        ui = 3'($urandom);
        rc = 2'($urandom);
        step();
      end
    end else begin
      ui = 3'($urandom) & 3'b101;
      rc = 2'b11;
      step();
      for (int f = 0; f < p_fc[k]; f++) begin
        n_checks++;
        if (obs !== {3'd5, 8'(f), 8'(l), 1'b0, ov_e, 2'b00}) begin
          n_fail++;
          $display("FAIL flush k=%0d f=%0d got %h exp %h", k, f, obs,
                   {3'd5, 8'(f), 8'(l), 1'b0, ov_e, 2'b00});
        end
        ui = 3'($urandom);
        rc = 2'($urandom);
        step();
      end
    end
    ui = 3'b000;
    rc = 2'b00;
    #1;
    n_checks++;
    if (obs !== 23'd0) begin
      n_fail++;
      $display("FAIL session_end k=%0d got %h exp %h", k, obs, 23'd0);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      n_checks++;
      if (obs !== 23'd0) begin
        n_fail++;
        $display("FAIL reset_state k=%0d got %h exp %h", k, obs, 23'd0);
      end
    end
  endtask

  task automatic test_transfer();
    run_session(0, 1'b0, 1'b0);
  endtask

  task automatic test_transfer_priority();
    run_session(0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    run_session(0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    run_session(1, 1'b0, 1'b0);
    run_session(1, 1'b1, 1'b0);
    run_session(2, 1'b0, 1'b0);
    run_session(2, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    repeat (12) run_session($urandom_range(0, 2), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_async_reset();
    sel = 0;
    ui = 3'b001;
    step();
    ui = 3'b100;
    step();
    ui = 3'b000;
    repeat (10) step();
    ui = 3'b010;
    step();
    ui = 3'b000;
    repeat (6) step();
    n_checks++;
    if ({st, lvl} !== {3'd4, 8'd4}) begin
      n_fail++;
      $display("FAIL pre_reset got ps=%0d lvl=%0d exp ps=4 lvl=4", st, lvl);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 23'd0) begin
      n_fail++;
      $display("FAIL async_reset got %h exp %h", obs, 23'd0);
    end
    #1 reset = 1'b0;
    step();
  endtask

  task automatic test_idle();
    sel = 0;
    ui = 3'b001;
    step();
    ui = 3'b100;
    step();
    ui = 3'b000;
    repeat (10) step();
`ifdef SCANNER_IDLE_TIMEOUT_EN
    for (int j = 0; j < 32; j++) begin
      n_checks++;
      if ({st, cnt} !== {3'd3, 8'(j)}) begin
        n_fail++;
        $display("FAIL idle_timer j=%0d got ps=%0d cnt=%0d exp ps=3 cnt=%0d", j, st, cnt, j);
      end
      step();
    end
    n_checks++;
    if (st !== 3'd5) begin
      n_fail++;
      $display("FAIL idle_timeout got %0d exp 5", st);
    end
    repeat (5) step();
`else
    for (int j = 0; j < 100; j++) begin
      n_checks++;
      if ({st, cnt} !== {3'd3, 8'd0}) begin
        n_fail++;
        $display("FAIL idle_wait j=%0d got ps=%0d cnt=%0d exp ps=3 cnt=0", j, st, cnt);
      end
      step();
    end
    ui = 3'b010;
    step();
    ui = 3'b000;
    repeat (10) step();
`endif
    n_checks++;
    if (obs !== 23'd0) begin
      n_fail++;
      $display("FAIL idle_exit got %h exp %h", obs, 23'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    sel = 0;
    ui = 3'b000;
    rc = 2'b00;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    step();
    test_transfer();
    test_transfer_priority();
    test_flush();
    test_overflow();
    test_random();
    test_async_reset();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/scanner_ctrl_param.md
Name: scanner_ctrl_param

Overview:
Parametrised successor to the two-scanner handshake controller. A single scanner FSM that runs the low-power, standby, collect, idle, transfer and flush cycle against a peer scanner over a 2-bit comm bus. Scan length, flush length and peer-signal timing are all parameters. It adds a buffer-occupancy model: level counting, transfer-until-empty, and a sticky overflow flag. Two instances are cross-connected (transmitComm to receiveComm) at lab top level.

Parameters:
- SCAN_CYCLES, 10, cycles spent in COLLECTING (>=1).
- FLUSH_CYCLES, 5, cycles spent in FLUSHING (>=1).
- STBY_LEAD, 2, GO_TO_STANDBY asserted when count == SCAN_CYCLES-1-STBY_LEAD.
- SCAN_LEAD, 1, START_SCAN asserted when count == SCAN_CYCLES-1-SCAN_LEAD.
- FLUSH_LEAD, 4, START_FLUSH asserted when count == SCAN_CYCLES-1-FLUSH_LEAD.
- DEPTH, 16, buffer capacity in samples.
- CNT_W, 8, state-timer width; must hold max(SCAN_CYCLES, FLUSH_CYCLES, IDLE_TIMEOUT).
- IDLE_TIMEOUT, 32, idle cycles before auto-flush (optional feature only).
- LVL_W, localparam = clog2(DEPTH+1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- userInput  in  3  [0] wake, [1] transfer request, [2] start scan.
- receiveComm  in  2  peer command: 00 INACTIVE, 01 GO_TO_STANDBY, 10 START_SCAN, 11 START_FLUSH.
- transmitComm  out  2  command to peer, same encoding; combinational from ps and count.
- ps  out  3  state: LOWPOWER 000, STANDBY 001, COLLECTING 010, IDLE 011, TRANSFERRING 100, FLUSHING 101.
- count  out  CNT_W  state timer.
- bufLevel  out  LVL_W  buffered sample count.
- dataValid  out  1  high in every TRANSFERRING cycle.
- overflow  out  1  sticky overflow flag.

Behaviour:
- Reset (async): ps=LOWPOWER, count=0, bufLevel=0, overflow=0. transmitComm=00 and dataValid=0 follow from state. Reset mid-operation aborts immediately; no peer signal is emitted.
- count clears to 0 on every state change. It increments each cycle in COLLECTING, FLUSHING, and in IDLE when the optional feature is on. Otherwise it holds 0.
- LOWPOWER -> STANDBY when userInput[0]=1 or receiveComm==01. On entering LOWPOWER, overflow is cleared.
- STANDBY -> COLLECTING when userInput[2]=1 or receiveComm==10.
- COLLECTING:
  - Each cycle bufLevel += 1, saturating at DEPTH.
  - An increment attempted at DEPTH sets overflow=1.
  - Exits to IDLE on the cycle count == SCAN_CYCLES-1, so the state lasts exactly SCAN_CYCLES cycles.
- transmitComm in COLLECTING (00 in all other states):
  - 01, 10 or 11 on the count matches defined by the *_LEAD parameters.
  - If lead values collide, priority is 11 > 10 > 01.
  - A lead value >= SCAN_CYCLES never fires.
- IDLE:
  - userInput[1]=1 -> TRANSFERRING.
  - Otherwise receiveComm==11 -> FLUSHING.
  - Transfer wins when both are present.
- TRANSFERRING:
  - dataValid=1 and bufLevel -= 1 each cycle.
  - On the cycle bufLevel==1, next state is LOWPOWER and bufLevel becomes 0.
  - If entered with bufLevel==0, one dataValid cycle is emitted with no decrement, then LOWPOWER.
- FLUSHING: lasts FLUSH_CYCLES cycles. On exit bufLevel=0 and next state is LOWPOWER.
- Peer inputs arriving in states that do not consume them are ignored and not latched.
- Default (illegal ps): next state LOWPOWER.

Optional Feature:
- Macro: SCANNER_IDLE_TIMEOUT_EN.
- Defined: count runs in IDLE. If count == IDLE_TIMEOUT-1 with no transfer or flush request that cycle, next state is FLUSHING. A request on that same cycle takes precedence.
- Undefined: IDLE waits indefinitely, count holds 0, and IDLE_TIMEOUT is unused.

Test Plan:
- Defaults, reset, userInput=001 for 1 cycle, then 100 -> ps 000->001->010. transmitComm=01 at count 7, 10 at count 8, 11 at count 5. ps=011 after 10 COLLECTING cycles; bufLevel=10.
- From IDLE with bufLevel=10, userInput=010 -> exactly 10 dataValid cycles, bufLevel 10..1 then 0, ps=000. Repeat with userInput[1] and receiveComm=11 together -> TRANSFERRING chosen.
- From IDLE, receiveComm=11 -> 5 FLUSHING cycles, then ps=000 and bufLevel=0.
- SCAN_CYCLES=20, DEPTH=16 -> bufLevel saturates at 16, overflow=1 from the 17th collect cycle, overflow clears on LOWPOWER entry.
- Assert reset during TRANSFERRING at bufLevel=4 -> same cycle (async): ps=000, bufLevel=0, count=0, dataValid=0, transmitComm=00.
- With SCANNER_IDLE_TIMEOUT_EN, IDLE_TIMEOUT=32 -> FLUSHING entered 32 cycles after IDLE entry. Without the macro, ps stays 011 for 100 cycles.
